mest_run_ctrl: RTL and testbench

Run sequencer for the `mest_pro` core. It accepts a run request, optionally pulses the core's memory reset, issues the start pulse, and supervises execution with a watchdog. Every `o_valid_result` beat is captured into a small result FIFO that a host or display path can drain. Sits between the host/stimulus logic and `mest_pro`, replacing hand-driven `i_start`/`i_memory_reset` sequencing.

---
 rtl/mest_run_ctrl_pkg.sv | 24 ++
 rtl/mest_run_ctrl_if.sv | 27 ++
 rtl/mest_result_fifo.sv | 59 +++++
 rtl/mest_run_ctrl.sv | 140 ++++++++++++++
 tb/tb_mest_run_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mest_run_ctrl_pkg.sv
// Shared types and constants for the mest_pro run sequencer.
//   run_state_t    : sequencer state encoding
//   result_beat_t  : one captured core beat, {carry, zero, result}
//   BEAT_CNT_WIDTH : width of the per-run beat counter and run counter
package mest_ctrl_pkg;

    localparam int BEAT_CNT_WIDTH   = 16;
    localparam int RESULT_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        RS_IDLE    = 3'd0,
        RS_MEM_RST = 3'd1,
        RS_START   = 3'd2,
        RS_RUN     = 3'd3,
        RS_DONE    = 3'd4
    } run_state_t;

    typedef struct packed {
        logic                        carry;
        logic                        zero;
        logic [RESULT_WIDTH_DEF-1:0] result;
    } result_beat_t;

endpackage

// File: rtl/mest_run_ctrl_if.sv
// Core-side and result-read-side signals of the run sequencer.
//   master : the sequencer (drives core start/memory reset, presents FIFO head)
//   slave  : core plus host read path
interface mest_run_ctrl_if #(
    parameter int RESULT_WIDTH = 8
);
    logic                    o_start;
    logic                    o_memory_reset;
    logic [RESULT_WIDTH-1:0] i_result;
    logic                    i_valid_result;
    logic                    i_carry;
    logic                    i_zero_flag;
    logic                    i_all_done;
    logic [RESULT_WIDTH+1:0] o_rd_data;
    logic                    o_rd_valid;
    logic                    i_rd_ready;

    modport master (
        output o_start, o_memory_reset, o_rd_data, o_rd_valid,
        input  i_result, i_valid_result, i_carry, i_zero_flag, i_all_done, i_rd_ready
    );

    modport slave (
        input  o_start, o_memory_reset, o_rd_data, o_rd_valid,
        output i_result, i_valid_result, i_carry, i_zero_flag, i_all_done, i_rd_ready
    );
endinterface

// File: rtl/mest_result_fifo.sv
// Synchronous FIFO for captured result beats.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : empties the FIFO (wins over push/pop)
//   push, wr_data : write request; accepted when not full, or full with a pop
//   pop           : removes the head; ignored when empty
//   rd_data       : current head
//   full, empty   : occupancy flags
module mest_result_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a pop frees the slot in the same edge, so a full FIFO still accepts
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mest_run_ctrl.sv
// Run sequencer for the mest_pro core: optional memory reset, start pulse,
// watchdog-supervised run, and capture of result beats into a FIFO.
//   clk, i_reset          : clock, synchronous active-high reset
//   i_go, i_clear_mem     : run request (IDLE only) and memory-reset option
//   i_abort               : terminate the current run
//   bus                   : core start/reset/result signals and FIFO read port
//   o_busy, o_done        : state != IDLE, completion pulse
//   o_timeout, o_overflow : sticky watchdog and dropped-beat flags
//   o_beat_count          : beats seen this run (saturating)
//   o_run_count           : completed runs (wrapping)
//
// state   | meaning
// IDLE    | waiting for i_go
// MEM_RST | o_memory_reset held high for MEM_RESET_CYCLES cycles
// START   | o_start pulse, watchdog reload
// RUN     | capturing beats, waiting for i_all_done or watchdog
// DONE    | o_done pulse, run counted
module mest_run_ctrl
    import mest_ctrl_pkg::*;
#(
    parameter int RESULT_WIDTH     = 8,
    parameter int FIFO_DEPTH       = 8,
    parameter int MEM_RESET_CYCLES = 4,
    parameter int TIMEOUT_CYCLES   = 65536
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic                      i_go,
    input  logic                      i_clear_mem,
    input  logic                      i_abort,
    mest_run_ctrl_if.master           bus,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_timeout,
    output logic                      o_overflow,
    output logic [BEAT_CNT_WIDTH-1:0] o_beat_count,
    output logic [BEAT_CNT_WIDTH-1:0] o_run_count
);
    localparam logic [2:0] S_IDLE    = RS_IDLE;
    localparam logic [2:0] S_MEM_RST = RS_MEM_RST;
    localparam logic [2:0] S_START   = RS_START;
    localparam logic [2:0] S_RUN     = RS_RUN;
    localparam logic [2:0] S_DONE    = RS_DONE;

    localparam int              MC_W    = $clog2(MEM_RESET_CYCLES + 1);
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MEM_RESET_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]              state;
    logic [2:0]              state_nxt;
    logic [MC_W-1:0]         mem_cnt;
    logic [WD_W-1:0]         wd_cnt;
    logic                    go_accept;
    logic                    beat_push;
    logic                    beat_drop;
    logic                    wd_expired;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [RESULT_WIDTH+1:0] beat_data;

    assign go_accept  = (state == S_IDLE) && i_go;
    assign beat_push  = (state == S_RUN) && bus.i_valid_result;
    assign beat_data  = {bus.i_carry, bus.i_zero_flag, bus.i_result};
    assign beat_drop  = beat_push && fifo_full && !bus.i_rd_ready;
    // abort and all_done both outrank the watchdog
    assign wd_expired = (state == S_RUN) && !i_abort && !bus.i_all_done && (wd_cnt == '0);
    assign bus.o_rd_valid = !fifo_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (i_go) state_nxt = i_clear_mem ? S_MEM_RST : S_START;
            S_MEM_RST: if (i_abort) state_nxt = S_IDLE;
                       else if (mem_cnt == '0) state_nxt = S_START;
            S_START:   state_nxt = i_abort ? S_IDLE : S_RUN;
            S_RUN:     if (i_abort) state_nxt = S_IDLE;
                       else if (bus.i_all_done) state_nxt = S_DONE;
                       else if (wd_cnt == '0) state_nxt = S_IDLE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state              <= S_IDLE;
            mem_cnt            <= '0;
            wd_cnt             <= '0;
            bus.o_start        <= 1'b0;
            bus.o_memory_reset <= 1'b0;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
            o_timeout          <= 1'b0;
            o_overflow         <= 1'b0;
            o_beat_count       <= '0;
            o_run_count        <= '0;
        end else begin
            state              <= state_nxt;
            bus.o_start        <= (state_nxt == S_START);
            bus.o_memory_reset <= (state_nxt == S_MEM_RST);
            o_busy             <= (state_nxt != S_IDLE);
            o_done             <= (state_nxt == S_DONE);

            if (state_nxt == S_MEM_RST && state != S_MEM_RST) mem_cnt <= MC_LOAD;
            else if (state == S_MEM_RST && mem_cnt != '0)     mem_cnt <= mem_cnt - MC_W'(1);

            if (state == S_START)                        wd_cnt <= WD_LOAD;
            else if (state == S_RUN && wd_cnt != '0)     wd_cnt <= wd_cnt - WD_W'(1);

            if (state_nxt == S_DONE) o_run_count <= o_run_count + BEAT_CNT_WIDTH'(1);

            if (go_accept) begin
                o_timeout    <= 1'b0;
                o_overflow   <= 1'b0;
                o_beat_count <= '0;
            end else begin
                if (wd_expired) o_timeout  <= 1'b1;
                if (beat_drop)  o_overflow <= 1'b1;
                if (beat_push && o_beat_count != '1) o_beat_count <= o_beat_count + BEAT_CNT_WIDTH'(1);
            end
        end
    end

    mest_result_fifo #(
        .WIDTH (RESULT_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (i_reset),
        .clear   (go_accept),
        .push    (beat_push),
        .pop     (bus.i_rd_ready),
        .wr_data (beat_data),
        .rd_data (bus.o_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
endmodule

// File: tb/tb_mest_run_ctrl.sv
module tb_mest_run_ctrl;
    import mest_ctrl_pkg::*;

    logic        clk;
    logic        i_reset;
    logic        i_go;
    logic        i_clear_mem;
    logic        i_abort;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout;
    logic        o_overflow;
    logic [15:0] o_beat_count;
    logic [15:0] o_run_count;

    int n_vec = 0;
    int n_err = 0;

    mest_run_ctrl_if #(.RESULT_WIDTH(8)) bus ();

    mest_run_ctrl #(
        .RESULT_WIDTH     (8),
        .FIFO_DEPTH       (8),
        .MEM_RESET_CYCLES (4),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_go         (i_go),
        .i_clear_mem  (i_clear_mem),
        .i_abort      (i_abort),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_overflow   (o_overflow),
        .o_beat_count (o_beat_count),
        .o_run_count  (o_run_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, go, clr, abort, vld, cy, zf, all_done, rdy;
        logic [7:0] res;
        logic       start, mrst, busy, done, tmo, ovf, rdv;
        logic [9:0] rdd;
        logic [15:0] beats, runs;
    } vec_t;

    localparam int NV = 15;
    vec_t v [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] beat(input logic c, input logic z, input logic [7:0] r);
        result_beat_t b;
        b.carry  = c;
        b.zero   = z;
        b.result = r;
        return b;
    endfunction

    task automatic idle_inputs();
        i_reset = 1'b0; i_go = 1'b0; i_clear_mem = 1'b0; i_abort = 1'b0;
        bus.i_valid_result = 1'b0; bus.i_result = 8'h00; bus.i_carry = 1'b0;
        bus.i_zero_flag = 1'b0; bus.i_all_done = 1'b0; bus.i_rd_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] drain [8];

        //        rst   go    clr   abrt  vld   cy    zf    done  rdy   res     start mrst  busy  done  tmo   ovf   rdv   rdd       beats   runs
        v[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000,16'd0,16'd0};
        v[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,10'h000,16'd0,16'd0};
        v[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,10'h000,16'd0,16'd0};
        v[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h33, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,10'h000,16'd0,16'd0};
        v[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,10'h000,16'd0,16'd0};
        v[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,10'h000,16'd0,16'd0};
        v[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,10'h000,16'd0,16'd0};
        v[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h12, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,10'h012,16'd1,16'd0};
        v[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'hFF, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,10'h012,16'd2,16'd0};
        v[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,10'h012,16'd3,16'd1};
        v[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,10'h012,16'd3,16'd1};
        v[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,10'h2FF,16'd3,16'd1};
        v[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,10'h100,16'd3,16'd1};
        v[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000,16'd3,16'd1};
        v[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h55, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000,16'd3,16'd1};

        idle_inputs();
        i_reset = 1'b1;
        tick();
        tick();

        // table: reset, memory-reset run with three beats, drain
        for (int i = 0; i < NV; i++) begin
            i_reset = v[i].rst; i_go = v[i].go; i_clear_mem = v[i].clr; i_abort = v[i].abort;
            bus.i_valid_result = v[i].vld; bus.i_carry = v[i].cy; bus.i_zero_flag = v[i].zf;
            bus.i_all_done = v[i].all_done; bus.i_rd_ready = v[i].rdy; bus.i_result = v[i].res;
            tick();
            chk($sformatf("row%0d start", i), 32'(bus.o_start), 32'(v[i].start));
            chk($sformatf("row%0d mem_reset", i), 32'(bus.o_memory_reset), 32'(v[i].mrst));
            chk($sformatf("row%0d busy", i), 32'(o_busy), 32'(v[i].busy));
            chk($sformatf("row%0d done", i), 32'(o_done), 32'(v[i].done));
            chk($sformatf("row%0d timeout", i), 32'(o_timeout), 32'(v[i].tmo));
            chk($sformatf("row%0d overflow", i), 32'(o_overflow), 32'(v[i].ovf));
            chk($sformatf("row%0d rd_valid", i), 32'(bus.o_rd_valid), 32'(v[i].rdv));
            if (v[i].rdv) chk($sformatf("row%0d rd_data", i), 32'(bus.o_rd_data), 32'(v[i].rdd));
            chk($sformatf("row%0d beat_count", i), 32'(o_beat_count), 32'(v[i].beats));
            chk($sformatf("row%0d run_count", i), 32'(o_run_count), 32'(v[i].runs));
        end
        idle_inputs();

        // overflow: fill 8, full+push+pop accepted, then two dropped beats
        i_go = 1'b1; tick(); i_go = 1'b0;
        chk("ovf_seq start", 32'(bus.o_start), 32'd1);
        tick();
        chk("ovf_seq beats_cleared", 32'(o_beat_count), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            bus.i_valid_result = 1'b1; bus.i_result = 8'(i);
            tick();
            chk($sformatf("ovf_seq beats%0d", i), 32'(o_beat_count), 32'(i));
            chk($sformatf("ovf_seq rd_valid%0d", i), 32'(bus.o_rd_valid), 32'd1);
        end
        chk("ovf_seq full_no_ovf", 32'(o_overflow), 32'd0);
        chk("ovf_seq head1", 32'(bus.o_rd_data), 32'(beat(1'b0, 1'b0, 8'h01)));
        bus.i_result = 8'hAA; bus.i_rd_ready = 1'b1;
        tick();
        bus.i_rd_ready = 1'b0;
        chk("ovf_seq pushpop_no_ovf", 32'(o_overflow), 32'd0);
        chk("ovf_seq head2", 32'(bus.o_rd_data), 32'(beat(1'b0, 1'b0, 8'h02)));
        bus.i_result = 8'h09; tick();
        chk("ovf_seq first_drop", 32'(o_overflow), 32'd1);
        bus.i_result = 8'h0A; tick();
        bus.i_valid_result = 1'b0;
        chk("ovf_seq overflow", 32'(o_overflow), 32'd1);
        chk("ovf_seq beats11", 32'(o_beat_count), 32'd11);
        bus.i_all_done = 1'b1; tick(); bus.i_all_done = 1'b0;
        chk("ovf_seq done", 32'(o_done), 32'd1);
        chk("ovf_seq run_count", 32'(o_run_count), 32'd2);
        tick();
        chk("ovf_seq done_one_cycle", 32'(o_done), 32'd0);
        chk("ovf_seq idle", 32'(o_busy), 32'd0);
        for (int j = 0; j < 7; j++) drain[j] = beat(1'b0, 1'b0, 8'(j + 2));
        drain[7] = beat(1'b0, 1'b0, 8'hAA);
        bus.i_rd_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("drain%0d valid", j), 32'(bus.o_rd_valid), 32'd1);
            chk($sformatf("drain%0d data", j), 32'(bus.o_rd_data), 32'(drain[j]));
            tick();
        end
        bus.i_rd_ready = 1'b0;
        chk("drain empty", 32'(bus.o_rd_valid), 32'd0);

        // watchdog: RUN entered in cycle 2, timeout visible in cycle 18
        i_go = 1'b1; tick(); i_go = 1'b0;
        chk("wd overflow_cleared", 32'(o_overflow), 32'd0);
        chk("wd beats_cleared", 32'(o_beat_count), 32'd0);
        tick();
        for (int c = 3; c <= 17; c++) begin
            tick();
            chk($sformatf("wd cyc%0d timeout", c), 32'(o_timeout), 32'd0);
            chk($sformatf("wd cyc%0d busy", c), 32'(o_busy), 32'd1);
            chk($sformatf("wd cyc%0d done", c), 32'(o_done), 32'd0);
        end
        tick();
        chk("wd timeout", 32'(o_timeout), 32'd1);
        chk("wd busy_low", 32'(o_busy), 32'd0);
        chk("wd no_done", 32'(o_done), 32'd0);
        tick();
        chk("wd sticky", 32'(o_timeout), 32'd1);
        chk("wd no_done2", 32'(o_done), 32'd0);
        chk("wd run_count", 32'(o_run_count), 32'd2);

        // next go clears timeout; abort+all_done keeps FIFO, no done
        i_go = 1'b1; tick(); i_go = 1'b0;
        chk("abort timeout_cleared", 32'(o_timeout), 32'd0);
        chk("abort start", 32'(bus.o_start), 32'd1);
        tick();
        bus.i_valid_result = 1'b1; bus.i_result = 8'h77; tick(); bus.i_valid_result = 1'b0;
        chk("abort beat_valid", 32'(bus.o_rd_valid), 32'd1);
        i_abort = 1'b1; bus.i_all_done = 1'b1; tick(); i_abort = 1'b0; bus.i_all_done = 1'b0;
        chk("abort busy", 32'(o_busy), 32'd0);
        chk("abort no_done", 32'(o_done), 32'd0);
        chk("abort run_count", 32'(o_run_count), 32'd2);
        tick();
        chk("abort no_done_late", 32'(o_done), 32'd0);
        chk("abort fifo_kept", 32'(bus.o_rd_data), 32'(beat(1'b0, 1'b0, 8'h77)));
        chk("abort fifo_valid", 32'(bus.o_rd_valid), 32'd1);

        // reset during MEM_RST
        i_go = 1'b1; i_clear_mem = 1'b1; tick(); i_go = 1'b0; i_clear_mem = 1'b0;
        chk("rst mem_reset_high", 32'(bus.o_memory_reset), 32'd1);
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        chk("rst mem_reset", 32'(bus.o_memory_reset), 32'd0);
        chk("rst start", 32'(bus.o_start), 32'd0);
        chk("rst busy", 32'(o_busy), 32'd0);
        chk("rst run_count", 32'(o_run_count), 32'd0);
        chk("rst beats", 32'(o_beat_count), 32'd0);
        chk("rst rd_valid", 32'(bus.o_rd_valid), 32'd0);
        chk("rst flags", 32'({o_done, o_timeout, o_overflow}), 32'd0);
        tick();
        chk("rst stays_idle", 32'({o_busy, bus.o_memory_reset, bus.o_start}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
